// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Parallel-to-serial frame transmitter. Each word accepted on a valid/ready
// handshake goes out on a single serial line as a start bit (0), the data
// bits LSB first, an optional parity bit and a stop bit (1). Every bit is
// held for CLKS_PER_BIT clock cycles. The line idles high. A complementary
// copy (tx_bar) is driven alongside it. All outputs come straight from
// flip-flops.
//
// Ports:
//   clock     system clock; all logic runs on its rising edge
//   reset_n   synchronous active-low reset
//   in_data   word to transmit; captured only on a handshake
//   in_valid  in_data holds a word
//   in_ready  the block will accept a word on this edge
//   tx        serial line
//   tx_bar    inverse of tx, changing on the same edge
//   busy      a frame is in progress
//   done      one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module serial_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              tx_bar,
   output logic              busy,
   output logic              done
);

   localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state;
   state_t state_next;

   logic [DATA_W-1:0] shift;       // bits not yet put on the line
   logic [BIT_W-1:0]  bit_cnt;     // index of the data bit now on the line
   logic [DIV_W-1:0]  div_cnt;     // cycles elapsed within the current bit
   logic              parity_bit;  // computed once when the word is captured

   logic accept;
   logic bit_end;
   logic last_data;

   logic tx_next;
   logic ready_next;
   logic busy_next;
   logic done_next;

   // in_ready is only ever high in IDLE, so this is the handshake edge.
   assign accept    = in_valid & in_ready;
   assign bit_end   = (state != IDLE) && (div_cnt == DIV_LAST);
   assign last_data = (bit_cnt == BIT_LAST);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values present before the edge, whatever the block order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: each combinational output gets a default before the case so that
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA: begin
            if (bit_end && last_data) begin
               if (PARITY_EN) state_next = PARITY;
               else           state_next = STOP;
            end
         end
         PARITY:  if (bit_end) state_next = STOP;
         STOP:    if (bit_end) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic: next values of the registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      tx_next    = tx;
      ready_next = in_ready;
      busy_next  = busy;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               tx_next    = 1'b0;
               ready_next = 1'b0;
               busy_next  = 1'b1;
            end
         end
         START, DATA: begin
            if (bit_end) begin
               if (state == DATA && last_data) begin
                  tx_next = PARITY_EN ? parity_bit : 1'b1;
               end else begin
                  tx_next = shift[0];
               end
            end
         end
         PARITY: begin
            if (bit_end) tx_next = 1'b1;
         end
         STOP: begin
            if (bit_end) begin
               ready_next = 1'b1;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end
         end
         default: begin
            tx_next    = 1'b1;
            ready_next = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------------------
   // NOTE: every datapath register is cleared by reset so a frame aborted
   // mid-flight leaves no stale bits or counts behind.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         shift      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         parity_bit <= 1'b0;
         tx         <= 1'b1;
         tx_bar     <= 1'b0;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (accept) begin
            shift      <= in_data;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            parity_bit <= (^in_data) ^ PARITY_ODD;
         end else if (state != IDLE) begin
            div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
            // The bit that goes on the line next is always shift[0]; drop it
            // from the register as it is launched.
            if (bit_end && (state == START || (state == DATA && !last_data))) begin
               shift <= shift >> 1;
               if (state == DATA) bit_cnt <= bit_cnt + 1'b1;
            end
         end
         tx       <= tx_next;
         tx_bar   <= ~tx_next;
         in_ready <= ready_next;
         busy     <= busy_next;
         done     <= done_next;
      end
   end

endmodule
